// File: rtl/dice_roll_engine.sv
// dice_roll_engine
// Turns a serial random bit stream into a fair roll of the selected die.
// A collector packs bits into 7-bit words. An FSM maps each word to 1..N by
// rejection sampling and holds the result. The roll can optionally be sent
// as one UART 8N1 frame.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset_n    synchronous active-low reset
//   i_data_in    raw random bit, sampled every clock while collecting
//   i_dieSelect  die code: 1 D4, 2 D6, 3 D8, 4 D12, 5 D20, 6 D10, 7 D2; else idle
//   i_uart       1 = transmit each completed roll on o_tx
//   o_dieRoll    roll result 1..N (0 before the first roll)
//   o_rollValid  high while a fresh roll is held
//   o_stop       high = collector halted, low = collecting
//   o_tx         UART serial output, idle high
module dice_roll_engine #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_data_in,
  input  logic [3:0] i_dieSelect,
  input  logic       i_uart,
  output logic [4:0] o_dieRoll,
  output logic       o_rollValid,
  output logic       o_stop,
  output logic       o_tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  // Codes 1..7 select a die; 0 and every code with the MSB set are idle.
  function automatic logic code_valid(input logic [3:0] c);
    return (c[3] == 1'b0) && (c[2:0] != 3'b000);
  endfunction

  // Largest multiple of N that fits in 128; words at or above it are
  // rejected so every face is equally likely.
  function automatic logic [7:0] accept_limit(input logic [2:0] c);
    logic [7:0] lim;
    case (c)
      3'd2:              lim = 8'd126;
      3'd4, 3'd5, 3'd6:  lim = 8'd120;
      default:           lim = 8'd128;
    endcase
    return lim;
  endfunction

  function automatic logic [4:0] map_roll(input logic [6:0] w, input logic [2:0] c);
    logic [6:0] m;
    case (c)
      3'd1:    m = w % 7'd4;
      3'd2:    m = w % 7'd6;
      3'd3:    m = w % 7'd8;
      3'd4:    m = w % 7'd12;
      3'd5:    m = w % 7'd20;
      3'd6:    m = w % 7'd10;
      3'd7:    m = w % 7'd2;
      default: m = 7'd0;
    endcase
    return 5'(m + 7'd1);
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic             w_latch_code;
  logic             w_load_roll;
  logic             w_accept;
  logic             w_start;
  logic             w_uart_busy;

  logic [5:0]       r_shift;
  logic [6:0]       w_shift_next;
  logic [2:0]       r_cnt;
  logic [6:0]       r_word;
  logic             r_word_valid;

  logic [2:0]       r_code;
  logic [4:0]       r_roll;
  logic             r_tx_start;

  logic             r_tx_active;
  logic             r_tx;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [3:0]       r_bit_idx;
  logic [8:0]       r_frame;

  // Collector: shift in while the FSM is waiting for a word
  assign w_start      = ~o_stop;
  assign w_shift_next = {r_shift, i_data_in};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt        <= 3'd0;
      r_word       <= 7'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (w_start) begin
        if (r_cnt == 3'd6) begin
          r_word       <= w_shift_next;
          r_word_valid <= 1'b1;
          r_cnt        <= 3'd0;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end else begin
        // A halted collector restarts from an empty word.
        r_cnt <= 3'd0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_start) begin
      r_shift <= w_shift_next[5:0];
    end
  end

  // Post-processing FSM
  assign w_accept    = {1'b0, r_word} < accept_limit(r_code);
  assign w_uart_busy = r_tx_active | r_tx_start;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch_code = 1'b0;
    w_load_roll  = 1'b0;
    o_stop       = 1'b1;
    o_rollValid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (code_valid(i_dieSelect)) begin
          w_latch_code = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        o_stop = 1'b0;
        if (!code_valid(i_dieSelect)) begin
          w_state_next = S_IDLE;
        end else if (r_word_valid && w_accept) begin
          w_load_roll  = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_rollValid = 1'b1;
        // Leaving requires an idle code, so a new roll always starts from IDLE.
        if (!code_valid(i_dieSelect) && !w_uart_busy) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_latch_code) begin
      r_code <= i_dieSelect[2:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_roll     <= 5'd0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= w_load_roll & i_uart;
      if (w_load_roll) begin
        r_roll <= map_roll(r_word, r_code);
      end
    end
  end

  assign o_dieRoll = r_roll;

  // UART transmitter: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_tx_active <= 1'b0;
      r_tx        <= 1'b1;
      r_clk_cnt   <= '0;
      r_bit_idx   <= 4'd0;
    end else if (r_tx_start) begin
      r_tx_active <= 1'b1;
      r_tx        <= 1'b0;
      r_clk_cnt   <= '0;
      r_bit_idx   <= 4'd0;
      r_frame     <= {1'b1, 3'b000, r_roll};
    end else if (r_tx_active) begin
      if (r_clk_cnt == LAST_CNT) begin
        r_clk_cnt <= '0;
        if (r_bit_idx == 4'd9) begin
          r_tx_active <= 1'b0;
          r_tx        <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= r_frame[0];
          r_frame   <= {1'b1, r_frame[8:1]};
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
      end
    end
  end

  assign o_tx = r_tx;

endmodule

// File: tb/tb_dice_roll_engine.sv
module tb_dice_roll_engine;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic [3:0] sel;
  logic       uart;
  logic [4:0] o_dieRoll;
  logic       o_rollValid;
  logic       o_stop;
  logic       o_tx;

  int checks   = 0;
  int failures = 0;
  logic [4:0] last_roll = 5'd0;

  dice_roll_engine #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_data_in   (din),
    .i_dieSelect (sel),
    .i_uart      (uart),
    .o_dieRoll   (o_dieRoll),
    .o_rollValid (o_rollValid),
    .o_stop      (o_stop),
    .o_tx        (o_tx)
  );

  always #5 clk = ~clk;

  function automatic int die_n(input logic [3:0] c);
    case (c)
      4'd1: return 4;
      4'd2: return 6;
      4'd3: return 8;
      4'd4: return 12;
      4'd5: return 20;
      4'd6: return 10;
      4'd7: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Select idle code and wait (bounded) until the block is back in IDLE.
  task automatic go_idle(input int budget);
    int n;
    n = 0;
    sel = 4'b1111;
    while ((o_stop !== 1'b1 || o_rollValid !== 1'b0) && n <= budget) begin
      tick;
      n++;
    end
    checks++;
    if (n > budget) begin
      failures++;
      $display("FAIL go_idle: still busy after %0d cycles (required <= %0d)", n, budget);
    end
  endtask

  // Start a roll from IDLE and follow it word by word. Words are built from
  // the bits the bench drives; the reference decides accept/reject with the
  // rule "word < floor(128/N)*N" and predicts (word mod N)+1.
  task automatic do_roll(input logic [3:0] code, input bit use_uart, input int nforced,
                         input logic [6:0] f0, input logic [6:0] f1, output logic [4:0] roll);
    int n, lim, t, widx, e;
    bit done;
    logic [6:0] cur, w;
    logic [6:0] words[$];
    n = die_n(code);
    lim = (128 / n) * n;
    roll = 5'd0;
    uart = use_uart;
    sel = code;
    tick;
    checks++;
    if (o_stop !== 1'b0) begin
      failures++;
      $display("FAIL wait_entry: o_stop=%b required 0 (code %0d)", o_stop, code);
    end
    t = 0;
    done = 0;
    cur = 7'd0;
    while (!done) begin
      if (t % 7 == 0) begin
        widx = t / 7;
        if (widx >= 20) begin
          checks++;
          failures++;
          $display("FAIL roll_timeout: no accepted word after %0d words", widx);
          break;
        end
        if (widx == 0 && nforced > 0)      cur = f0;
        else if (widx == 1 && nforced > 1) cur = f1;
        else                               cur = 7'($urandom_range(0, 127));
        words.push_back(cur);
      end
      din = cur[6];
      cur = {cur[5:0], 1'b0};
      tick;
      t++;
      if (t >= 8 && (t - 8) % 7 == 0) begin
        w = words.pop_front();
        if (int'(w) < lim) begin
          e = int'(w) % n + 1;
          checks++;
          if (o_dieRoll !== 5'(e) || o_rollValid !== 1'b1 || o_stop !== 1'b1) begin
            failures++;
            $display("FAIL roll_accept: code %0d word %0d roll=%0d valid=%b stop=%b required roll=%0d valid=1 stop=1",
                     code, w, o_dieRoll, o_rollValid, o_stop, e);
          end
          if (!use_uart) begin
            checks++;
            if (o_tx !== 1'b1) begin
              failures++;
              $display("FAIL tx_quiet: o_tx=%b required 1", o_tx);
            end
          end
          roll = 5'(e);
          last_roll = 5'(e);
          done = 1;
        end else begin
          checks++;
          if (o_stop !== 1'b0 || o_rollValid !== 1'b0) begin
            failures++;
            $display("FAIL roll_reject: word %0d stop=%b valid=%b required stop=0 valid=0",
                     w, o_stop, o_rollValid);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sel = 4'b1111;
    uart = 1'b0;
    din = 1'b0;
    repeat (2) begin
      din = 1'($urandom_range(0, 1));
      tick;
    end
    checks++;
    if (o_stop !== 1'b1 || o_dieRoll !== 5'd0 || o_tx !== 1'b1 || o_rollValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: stop=%b roll=%0d tx=%b valid=%b required 1,0,1,0",
               o_stop, o_dieRoll, o_tx, o_rollValid);
    end
    rst_n = 1'b1;
    repeat (3) tick;
    checks++;
    if (o_stop !== 1'b1 || o_dieRoll !== 5'd0 || o_tx !== 1'b1 || o_rollValid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: stop=%b roll=%0d tx=%b valid=%b required 1,0,1,0",
               o_stop, o_dieRoll, o_tx, o_rollValid);
    end
  endtask

  task automatic test_forced_d20;
    logic [4:0] r;
    go_idle(20);
    do_roll(4'b0101, 1'b0, 1, 7'b0100110, 7'd0, r);
    checks++;
    if (r !== 5'd19) begin
      failures++;
      $display("FAIL forced_d20: roll=%0d required 19", r);
    end
  endtask

  task automatic test_rejection;
    logic [4:0] r;
    go_idle(20);
    do_roll(4'b0101, 1'b0, 2, 7'b1111011, 7'b0000000, r);
    checks++;
    if (o_dieRoll !== 5'd1) begin
      failures++;
      $display("FAIL rejection: roll=%0d required 1", o_dieRoll);
    end
  endtask

  task automatic test_uart(input logic [3:0] code, input int nforced, input logic [6:0] f0);
    logic [4:0] r;
    logic [9:0] frame;
    int n;
    go_idle(20 * CPB);
    do_roll(code, 1'b1, nforced, f0, 7'd0, r);
    checks++;
    if (o_tx !== 1'b1) begin
      failures++;
      $display("FAIL tx_entry_idle: o_tx=%b required 1", o_tx);
    end
    frame = {1'b1, 3'b000, r, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b == 0 && c == 1) sel = 4'b1111;
        tick;
        checks++;
        if (o_tx !== frame[0] || o_rollValid !== 1'b1) begin
          failures++;
          $display("FAIL tx_frame: bit %0d cycle %0d o_tx=%b valid=%b required tx=%b valid=1",
                   b, c, o_tx, o_rollValid, frame[0]);
        end
      end
      frame = {1'b1, frame[9:1]};
    end
    n = 0;
    while (o_rollValid !== 1'b0 && n <= 3) begin
      tick;
      n++;
    end
    checks++;
    if (n > 3 || o_tx !== 1'b1 || o_stop !== 1'b1) begin
      failures++;
      $display("FAIL tx_release: exit after %0d cycles tx=%b stop=%b required <=3,1,1", n, o_tx, o_stop);
    end
    uart = 1'b0;
  endtask

  task automatic test_abort;
    logic [4:0] prev;
    go_idle(20);
    prev = last_roll;
    uart = 1'b0;
    sel = 4'b0011;
    tick;
    checks++;
    if (o_stop !== 1'b0) begin
      failures++;
      $display("FAIL abort_wait: o_stop=%b required 0", o_stop);
    end
    repeat (3) begin
      din = 1'($urandom_range(0, 1));
      tick;
    end
    sel = 4'b1111;
    tick;
    checks++;
    if (o_stop !== 1'b1 || o_rollValid !== 1'b0 || o_dieRoll !== prev) begin
      failures++;
      $display("FAIL abort_idle: stop=%b valid=%b roll=%0d required 1,0,%0d",
               o_stop, o_rollValid, o_dieRoll, prev);
    end
  endtask

  task automatic test_hold;
    logic [4:0] r;
    int bad;
    go_idle(20);
    do_roll(4'b0101, 1'b0, 1, 7'd38, 7'd0, r);
    sel = 4'b0010;
    bad = 0;
    repeat (20) begin
      din = 1'($urandom_range(0, 1));
      tick;
      if (o_rollValid !== 1'b1 || o_stop !== 1'b1 || o_dieRoll !== r) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_done: %0d cycles left DONE or changed roll (required 0), roll=%0d", bad, o_dieRoll);
    end
    go_idle(5);
    do_roll(4'b0010, 1'b0, 1, 7'd100, 7'd0, r);
    checks++;
    if (r !== 5'd5) begin
      failures++;
      $display("FAIL hold_reroll: roll=%0d required 5", r);
    end
  endtask

  task automatic test_soak;
    logic [4:0] r;
    bit seen[1:20];
    int n;
    for (int i = 1; i <= 20; i++) seen[i] = 0;
    for (int i = 0; i < 300; i++) begin
      go_idle(5);
      do_roll(4'b0101, 1'b0, 0, 7'd0, 7'd0, r);
      if (r >= 5'd1 && r <= 5'd20) seen[int'(r)] = 1;
    end
    for (int v = 1; v <= 20; v++) begin
      checks++;
      if (!seen[v]) begin
        failures++;
        $display("FAIL soak_coverage: D20 value %0d never rolled (required present)", v);
      end
    end
    for (int code = 1; code <= 7; code++) begin
      n = die_n(4'(code));
      for (int i = 0; i < 20; i++) begin
        go_idle(5);
        do_roll(4'(code), 1'b0, 0, 7'd0, 7'd0, r);
        checks++;
        if (r < 5'd1 || int'(r) > n) begin
          failures++;
          $display("FAIL soak_range: code %0d roll=%0d required 1..%0d", code, r, n);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [4:0] r;
    int bad;
    go_idle(5);
    do_roll(4'b0100, 1'b1, 0, 7'd0, 7'd0, r);
    repeat (3 * CPB) tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if (o_tx !== 1'b1 || o_dieRoll !== 5'd0 || o_rollValid !== 1'b0 || o_stop !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_frame: tx=%b roll=%0d valid=%b stop=%b required 1,0,0,1",
               o_tx, o_dieRoll, o_rollValid, o_stop);
    end
    rst_n = 1'b1;
    sel = 4'b1111;
    uart = 1'b0;
    last_roll = 5'd0;
    bad = 0;
    repeat (12 * CPB) begin
      tick;
      if (o_tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL frame_resumed: o_tx low for %0d cycles after reset (required 0)", bad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_forced_d20;
    test_rejection;
    test_uart(4'b0010, 1, 7'd5);
    test_uart(4'b0101, 0, 7'd0);
    test_abort;
    test_hold;
    test_soak;
    test_reset_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
